// File: rtl/s2p_receiver_pkg.sv
// Shared definitions for the serial-to-parallel receiver: state encoding and
// default idle timeout.
package s2p_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam int IDLE_CYCLES_DEF = 16;

endpackage

// File: rtl/s2p_receiver_if.sv
// Serial link pins plus the parallel frame outputs of the receiver.
interface s2p_receiver_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 sclk;
    logic                 sdin;
    logic [BIT_WIDTH-1:0] par_out;
    logic                 valid;
    logic                 busy;
    logic                 frame_err;

    modport master (output sclk, sdin, input par_out, valid, busy, frame_err);
    modport slave  (input sclk, sdin, output par_out, valid, busy, frame_err);
endinterface

// File: rtl/s2p_receiver_sync_edge.sv
// 2-FF synchronizer with a third alignment stage and a registered rising-edge
// detect on bit 0; the other bits ride along so they stay aligned with the edge.
module sync_edge #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise
);
    logic [WIDTH-1:0] m1, m2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1   <= RST_VAL;
            m2   <= RST_VAL;
            q    <= RST_VAL;
            rise <= 1'b0;
        end else begin
            m1   <= d;
            m2   <= m1;
            q    <= m2;
            // q still holds the previous m2 here, so this is m2 & ~m2_delayed
            rise <= m2[0] & ~q[0];
        end
    end
endmodule

// File: rtl/s2p_receiver.sv
// Receives LSB-first serial frames on sclk/sdin, ends a frame on an idle-high
// gap, and reports it as a valid pulse with par_out or a frame_err pulse.
module s2p_receiver
    import s2p_defs::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    s2p_receiver_if.slave   bus
);
    localparam int CW = $clog2(BIT_WIDTH + 2);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_WIDTH);
    localparam logic [CW-1:0] CNT_OVR  = CW'(BIT_WIDTH + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    logic [1:0]           sync_q;
    logic                 rise;
    logic                 sclk_s, sd_s;
    logic [IW-1:0]        idle_cnt;
    logic                 idle_done;
    logic [BIT_WIDTH-1:0] shreg, par_q;
    logic                 valid_q, err_q;
    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 good, bad, busy_c;

    sync_edge #(.WIDTH(2), .RST_VAL(2'b11)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    ({bus.sdin, bus.sclk}),
        .q    (sync_q),
        .rise (rise)
    );

    assign sclk_s    = sync_q[0];
    assign sd_s      = sync_q[1];
    assign idle_done = (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (!sclk_s)
            idle_cnt <= '0;
        else if (!idle_done)
            idle_cnt <= idle_cnt + IW'(1);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        good      = 1'b0;
        bad       = 1'b0;
        busy_c    = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = CW'(1);
                end
            end
            S_SHIFT: begin
                if (idle_done) begin
                    state_nxt = S_CHECK;
                    good      = (cnt == CNT_FULL);
                    bad       = (cnt != CNT_FULL);
                end else if (rise && cnt != CNT_OVR) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CHECK: begin
                // An edge here already belongs to the next frame
                if (rise) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = CW'(1);
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Verdict is registered on entry to CHECK so the pulse lines up with that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid_q <= good;
            err_q   <= bad;
            if (rise)
                shreg <= BIT_WIDTH'({sd_s, shreg} >> 1);
            if (good)
                par_q <= shreg;
        end
    end

    assign bus.par_out   = par_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_c;
endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel receiver for the LED/peripheral serial link: the receiving end of the parallel-to-serial shifter. It samples an external `sclk`/`sdin` pair, which is asynchronous to `clk`, and assembles `BIT_WIDTH` bits per frame, LSB first. A frame is delimited by an idle gap on `sclk`. The block presents each completed frame as a one-cycle `valid` pulse with `par_out`, and flags malformed frames.

## Interface
- `BIT_WIDTH`, default 8: data bits per frame.
- `IDLE_CYCLES`, default 16: consecutive `clk` cycles with synchronized `sclk` high that end a frame; minimum 4.
- `clk` input 1: system clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: serial clock; idles high; data is sampled on its rising edge.
- `sdin` input 1: serial data; stable around each `sclk` rising edge.
- `par_out` output `BIT_WIDTH`: last good frame; bit 0 is the first bit received.
- `valid` output 1: one-cycle pulse when `par_out` updates.
- `busy` output 1: high while a frame is in progress.
- `frame_err` output 1: one-cycle pulse when a frame ends with the wrong bit count.

## Operation
- **Synchronizer.** `sclk` and `sdin` each pass through a 2-FF synchronizer.
  - Rising-edge detect on synchronized `sclk`: `s_q1 & ~s_q2`, one extra register stage.
  - `sdin` is taken from the same synchronizer stage as the `sclk` edge, so both are aligned.
- **Shift register.** `BIT_WIDTH` bits. On each detected edge, shift right and insert the sampled bit at MSB. After `BIT_WIDTH` edges, bit 0 holds the first bit.
- **Bit counter.** Width is `$clog2(BIT_WIDTH+2)`. It saturates at `BIT_WIDTH+1`, which means overrun.
- **Idle counter.** Counts cycles with synchronized `sclk` high. It clears on synchronized `sclk` low and saturates at `IDLE_CYCLES`.
- **State machine:**
  - `IDLE`: `busy`=0. On an edge, go to `SHIFT`; that edge is counted as bit 1.
  - `SHIFT`: `busy`=1. Each edge increments the bit counter. When the idle counter reaches `IDLE_CYCLES`, go to `CHECK`.
  - `CHECK`: lasts one cycle.
    - If the count equals `BIT_WIDTH`: `par_out` ← shift register and pulse `valid`.
    - Otherwise: pulse `frame_err` and leave `par_out` unchanged.
    - Then clear the counter and go to `IDLE`.
- **Overrun.** More than `BIT_WIDTH` edges makes the frame bad. Further bits are ignored until the idle timeout, then `CHECK` reports `frame_err`.
- **Reset values.** `par_out`=0, `valid`=0, `busy`=0, `frame_err`=0. Synchronizers reset to 1 (idle-high), so reset never produces a spurious edge. State is `IDLE` and all counters are 0.
- **Reset mid-frame.** Partial data is discarded and no pulse is produced. The next frame is received normally only if `sclk` is idle high for at least 3 cycles before its first edge.
- **Edge in the `CHECK` cycle.** The edge is counted as bit 1 of a new frame: load the shift register, set the counter to 1, and go to `SHIFT` instead of `IDLE`.

## Timing
- **`sclk` constraints.** High and low phases must each be at least 2 `clk` cycles. `sdin` must be stable from 2 cycles before each `sclk` rising edge until 1 cycle after it. Faster `sclk` is out of spec and edges may be lost.
- **Edge latency.** An `sclk` rising edge at the pins is detected 3 `clk` cycles later (2 synchronizer stages + edge register).
- **Frame latency.** `valid`/`frame_err` rises `IDLE_CYCLES`+3 cycles after the last `sclk` rising edge, plus 1 cycle for `CHECK`.
- **Pulses.** `valid` and `frame_err` are registered, exactly 1 cycle wide, and never both high.
- **`par_out`** changes only in the cycle `valid` is high and holds otherwise.
- **Throughput.** Back-to-back frames need an inter-frame gap of at least `IDLE_CYCLES`+1 cycles of `sclk` high.

## Structure
- Shared package/header `s2p_defs`:
  - state encoding `S_IDLE`=2'd0, `S_SHIFT`=2'd1, `S_CHECK`=2'd2;
  - default `IDLE_CYCLES`.
- Sub-module `sync_edge`: 2-FF synchronizer with reset value parameter, plus registered rising-edge detect. Instantiate it for `sclk`; `sdin` uses the synchronizer part only.
- Top level holds the shift register, the two counters, and the state machine.

## Test plan
- **Good frame.** Reset, then send 0xA5 LSB first with 4-cycle `sclk` phases and a 20-cycle idle. Expect exactly one `valid` with `par_out`=0xA5, `frame_err` never high, and `busy` high from the first edge +3 cycles until `CHECK`.
- **Short frame.** Send 5 bits, then idle. Expect one `frame_err` pulse, no `valid`, and `par_out` holding the previous value (0xA5).
- **Overrun.** Send 10 bits. Expect `frame_err`, no `valid`. A following good frame 0x3C still produces `valid` with `par_out`=0x3C.
- **Back-to-back.** Send 0x01 then 0xFF separated by exactly `IDLE_CYCLES`+1 idle cycles. Expect two `valid` pulses with 0x01 then 0xFF.
- **Reset mid-frame.** Assert `rst` after 4 bits. Expect all outputs 0 immediately (asynchronous), no pulse after release, and the next good frame 0x5A received correctly.
- **Minimum timing.** Send 2-cycle `sclk` high/low with random data, 100 frames. Every `par_out` matches the sent value.
